// File: rtl/hf_mode_sequencer_pkg.sv
// Shared constants for the HF mode sequencer: opcodes, major modes, states.
// Imported by hf_seq_timer and hf_mode_sequencer.
package hf_mode_sequencer_pkg;

    localparam logic [3:0] FPGA_CMD_NOP         = 4'b0000;
    localparam logic [3:0] FPGA_CMD_SET_CONFREG = 4'b0001;

    localparam logic [2:0] HF_MODE_READER_TX       = 3'b000;
    localparam logic [2:0] HF_MODE_READER_RX_XCORR = 3'b001;
    localparam logic [2:0] HF_MODE_SIMULATE        = 3'b010;
    localparam logic [2:0] HF_MODE_ISO14443A       = 3'b011;
    localparam logic [2:0] HF_MODE_OFF             = 3'b111;

    localparam int TW = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_QUIET = 2'b01,
        ST_ALIGN = 2'b10,
        ST_APPLY = 2'b11
    } seq_state_t;

    function automatic logic mode_legal(input logic [2:0] m);
        return !(m inside {3'b100, 3'b101, 3'b110});
    endfunction

endpackage

// File: rtl/hf_seq_timer.sv
// Loadable down-counter with terminal flag; shared by the QUIET and
// ALIGN phases of the HF mode sequencer.
module hf_seq_timer
    import hf_mode_sequencer_pkg::*;
#(
    parameter int W = TW
) (
    input  logic         ck_1356meg,
    input  logic         nreset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         done
);

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/hf_mode_sequencer.sv
// Glitch-free HF major-mode/config sequencer (quiet, guard, frame align, apply).
// Optional status counters: define HF_MODE_SEQ_STATUS_EN.
module hf_mode_sequencer
    import hf_mode_sequencer_pkg::*;
#(
    parameter int GUARD_CYCLES  = 64,
    parameter int ALIGN_TIMEOUT = 255
) (
    input  logic        ck_1356meg,
    input  logic        nreset,
    input  logic [15:0] cmd_word,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        frame_tick,
    output logic [7:0]  conf_word,
    output logic [2:0]  eff_mode,
    output logic        hold_off,
`ifdef HF_MODE_SEQ_STATUS_EN
    output logic [15:0] status_word,
    input  logic        clr_status,
`endif
    output logic        busy
);

    localparam logic [TW-1:0] GUARD_LD = TW'(GUARD_CYCLES - 1);
    localparam logic [TW-1:0] ALIGN_LD = TW'(ALIGN_TIMEOUT - 1);

    seq_state_t    state, state_nxt;
    logic [7:0]    pending, pending_nxt;
    logic [7:0]    conf_nxt;
    logic          t_load, t_en, t_done;
    logic [TW-1:0] t_val, t_cnt;
    logic          rej_evt, forced_evt;
    logic [3:0]    opcode;
    logic [7:0]    payload;
    logic          unused_bits;

    assign opcode  = cmd_word[15:12];
    assign payload = cmd_word[7:0];

    hf_seq_timer #(.W(TW)) u_timer (
        .ck_1356meg (ck_1356meg),
        .nreset     (nreset),
        .load       (t_load),
        .en         (t_en),
        .load_val   (t_val),
        .cnt        (t_cnt),
        .done       (t_done)
    );

    assign t_en = (state == ST_QUIET) || (state == ST_ALIGN);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        conf_nxt    = conf_word;
        t_load      = 1'b0;
        t_val       = GUARD_LD;
        rej_evt     = 1'b0;
        forced_evt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (1'b1)
                        (opcode == FPGA_CMD_NOP): begin
                        end
                        (opcode == FPGA_CMD_SET_CONFREG): begin
                            if (!mode_legal(payload[7:5])) begin
                                rej_evt = 1'b1;
                            end else if (payload[7:5] == conf_word[7:5]) begin
                                conf_nxt = payload;
                            end else begin
                                pending_nxt = payload;
                                state_nxt   = ST_QUIET;
                                t_load      = 1'b1;
                                t_val       = GUARD_LD;
                            end
                        end
                        default: rej_evt = 1'b1;
                    endcase
                end
            end
            ST_QUIET: begin
                if (t_done) begin
                    t_load = 1'b1;
                    t_val  = ALIGN_LD;
                    // Switching off needs no carrier alignment
                    state_nxt = (pending[7:5] == HF_MODE_OFF) ? ST_APPLY
                                                              : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (frame_tick || t_done) begin
                    state_nxt  = ST_APPLY;
                    forced_evt = !frame_tick;
                end
            end
            ST_APPLY: begin
                conf_nxt  = pending;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            pending   <= 8'h00;
            conf_word <= 8'hE0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            conf_word <= conf_nxt;
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign hold_off  = busy;
    assign eff_mode  = hold_off ? HF_MODE_OFF : conf_word[7:5];

`ifdef HF_MODE_SEQ_STATUS_EN
    logic [7:0] rej_cnt;
    logic [4:0] forced_cnt;

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            rej_cnt    <= 8'h00;
            forced_cnt <= 5'h00;
        end else if (clr_status) begin
            rej_cnt    <= 8'h00;
            forced_cnt <= 5'h00;
        end else begin
            if (rej_evt && (rej_cnt != 8'hFF)) begin
                rej_cnt <= rej_cnt + 8'd1;
            end
            if (forced_evt && (forced_cnt != 5'h1F)) begin
                forced_cnt <= forced_cnt + 5'd1;
            end
        end
    end

    assign status_word = {rej_cnt, 1'b0, state, forced_cnt};
    assign unused_bits = ^{cmd_word[11:8], t_cnt};
`else
    assign unused_bits = ^{cmd_word[11:8], t_cnt, rej_evt, forced_evt};
`endif

endmodule

// File: tb/tb_hf_mode_sequencer.sv
// Self-checking bench for hf_mode_sequencer: vector table plus
// multi-cycle sequences, expected conf words tracked in a scoreboard queue.
module tb_hf_mode_sequencer;

    logic        ck;
    logic        nreset;
    logic [15:0] cmd_word;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        frame_tick;
    logic [7:0]  conf_word;
    logic [2:0]  eff_mode;
    logic        hold_off;
    logic        busy;
`ifdef HF_MODE_SEQ_STATUS_EN
    logic [15:0] status_word;
    logic        clr_status;
`endif

    int n_vec;
    int n_mis;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [15:0] word;
        logic [7:0]  conf;
        logic        rej;
    } vec_t;

    vec_t tbl[10];

    hf_mode_sequencer #(.GUARD_CYCLES(64), .ALIGN_TIMEOUT(255)) dut (
        .ck_1356meg (ck),
        .nreset     (nreset),
        .cmd_word   (cmd_word),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .frame_tick (frame_tick),
        .conf_word  (conf_word),
        .eff_mode   (eff_mode),
        .hold_off   (hold_off),
`ifdef HF_MODE_SEQ_STATUS_EN
        .status_word(status_word),
        .clr_status (clr_status),
`endif
        .busy       (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_idle(input string nm, input logic [15:0] w,
                             input logic [7:0] exp);
        @(negedge ck);
        cmd_word  = w;
        cmd_valid = 1'b1;
        sb_q.push_back(exp);
        @(posedge ck);
        #1 cmd_valid = 1'b0;
        @(negedge ck);
        chk({nm, " conf"}, 32'(conf_word), 32'(sb_q.pop_front()));
        chk({nm, " hold"}, 32'(hold_off), 32'd0);
        chk({nm, " ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_seq(input string nm, input logic [15:0] w,
                           input int tick_at, input int exp_hold,
                           input logic [7:0] exp_conf,
                           input logic [2:0] exp_eff,
                           input logic hold_next,
                           input logic [15:0] next_w);
        int hcnt;
        int bad;
        hcnt = 0;
        bad  = 0;
        @(negedge ck);
        cmd_word  = w;
        cmd_valid = 1'b1;
        sb_q.push_back(exp_conf);
        @(posedge ck);
        #1;
        if (hold_next) cmd_word = next_w;
        else cmd_valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            frame_tick = (c == tick_at) || (c == 5);
            @(negedge ck);
            if (!hold_off) break;
            hcnt++;
            if (eff_mode !== 3'b111 || cmd_ready !== 1'b0 || busy !== 1'b1)
                bad++;
            @(posedge ck);
            #1;
        end
        frame_tick = 1'b0;
        chk({nm, " hold cycles"}, 32'(hcnt), 32'(exp_hold));
        chk({nm, " outputs while held"}, 32'(bad), 32'd0);
        chk({nm, " conf"}, 32'(conf_word), 32'(sb_q.pop_front()));
        chk({nm, " eff"}, 32'(eff_mode), 32'(exp_eff));
        chk({nm, " ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int nrej;
        n_vec      = 0;
        n_mis      = 0;
        nrej       = 0;
        cmd_word   = 16'h0000;
        cmd_valid  = 1'b0;
        frame_tick = 1'b0;
        nreset     = 1'b0;
`ifdef HF_MODE_SEQ_STATUS_EN
        clr_status = 1'b0;
`endif
        tbl[0] = '{16'h10E3, 8'hE3, 1'b0};
        tbl[1] = '{16'h0000, 8'hE3, 1'b0};
        tbl[2] = '{16'h0055, 8'hE3, 1'b0};
        tbl[3] = '{16'h3000, 8'hE3, 1'b1};
        tbl[4] = '{16'h10A0, 8'hE3, 1'b1};
        tbl[5] = '{16'h10C7, 8'hE3, 1'b1};
        tbl[6] = '{16'h109F, 8'hE3, 1'b1};
        tbl[7] = '{16'hF0E1, 8'hE3, 1'b1};
        tbl[8] = '{16'h10FF, 8'hFF, 1'b0};
        tbl[9] = '{16'h10E0, 8'hE0, 1'b0};

        #12;
        chk("rst conf", 32'(conf_word), 32'hE0);
        chk("rst eff", 32'(eff_mode), 32'h7);
        chk("rst hold", 32'(hold_off), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(cmd_ready), 32'd1);
        @(negedge ck);
        nreset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send_idle($sformatf("vec%0d", i), tbl[i].word, tbl[i].conf);
            chk($sformatf("vec%0d eff", i), 32'(eff_mode),
                32'(tbl[i].conf[7:5]));
            if (tbl[i].rej) nrej++;
        end
`ifdef HF_MODE_SEQ_STATUS_EN
        chk("rej_cnt", 32'(status_word[15:8]), 32'(nrej));
`endif

        run_seq("to_rxx", 16'h1020, 73, 75, 8'h20, 3'b001, 1'b0, 16'h0);
        send_idle("minor", 16'h1021, 8'h21);
        send_idle("minor back", 16'h1020, 8'h20);
        run_seq("to_sim", 16'h1040, 73, 75, 8'h40, 3'b010, 1'b0, 16'h0);
        run_seq("timeout", 16'h1020, -1, 320, 8'h20, 3'b001, 1'b0, 16'h0);
`ifdef HF_MODE_SEQ_STATUS_EN
        chk("forced_cnt", 32'(status_word[4:0]), 32'd1);
        @(negedge ck);
        clr_status = 1'b1;
        @(negedge ck);
        clr_status = 1'b0;
        chk("clr status", 32'(status_word), 32'd0);
`endif
        run_seq("to_14a", 16'h1060, 73, 75, 8'h60, 3'b011, 1'b0, 16'h0);
        run_seq("switch off", 16'h10E0, -1, 65, 8'hE0, 3'b111, 1'b0, 16'h0);

        run_seq("backpressure", 16'h1020, 73, 75, 8'h20, 3'b001,
                1'b1, 16'h1021);
        @(posedge ck);
        #1 cmd_valid = 1'b0;
        @(negedge ck);
        chk("held word conf", 32'(conf_word), 32'h21);
        chk("held word hold", 32'(hold_off), 32'd0);

        @(negedge ck);
        cmd_word  = 16'h1040;
        cmd_valid = 1'b1;
        @(posedge ck);
        #1 cmd_valid = 1'b0;
        repeat (70) @(posedge ck);
        #2 nreset = 1'b0;
        #1;
        chk("midrst conf", 32'(conf_word), 32'hE0);
        chk("midrst eff", 32'(eff_mode), 32'h7);
        chk("midrst hold", 32'(hold_off), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst ready", 32'(cmd_ready), 32'd1);
        @(negedge ck);
        nreset = 1'b1;
        send_idle("post rst", 16'h10E5, 8'hE5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
